// File: rtl/gpmc_fifo_regs.sv
// Host-side register bank behind the GPMC synchronizer: ID, CTRL, STATUS, SCRATCH
// plus TX (host->fabric) and RX (fabric->host) first-word-fall-through FIFOs.
module gpmc_fifo_regs #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 16'hB3A7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            ctrl_out,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_TXLEVEL = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_RXLEVEL = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_TXDATA  = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] A_RXDATA  = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(8);

    logic                  we_d_reg, oe_d_reg, we_arm_reg;
    logic                  wr_commit, rd_end;
    logic                  wr_ctrl, wr_status, wr_scratch;
    logic                  tx_push_req, rx_pop_req;
    logic                  tx_ovf_set, rx_unf_set;
    logic [7:0]            ctrl_hi_reg;
    logic                  irq_en_rx_reg, irq_en_tx_reg;
    logic [DATA_WIDTH-1:0] scratch_reg;
    logic                  tx_ovf_reg, rx_unf_reg;
    logic [DATA_WIDTH-1:0] rd_mux, rd_data_reg;
    logic                  irq_reg;
    logic                  unused_cs;

    // Index 0 is the TX FIFO, index 1 the RX FIFO.
    logic [1:0]                 push, pop, clr, full, empty;
    logic [1:0][DATA_WIDTH-1:0] din, head;
    logic [1:0][LW-1:0]         level;

    assign unused_cs = cs;

    // we_d resets high, so a strobe held low across reset release would look like a
    // fresh falling edge; we_arm blocks commits until we has been seen high.
    assign wr_commit = !we && we_d_reg && we_arm_reg;
    assign rd_end    = oe && !oe_d_reg;

    assign wr_ctrl     = wr_commit && (address == A_CTRL);
    assign wr_status   = wr_commit && (address == A_STATUS);
    assign wr_scratch  = wr_commit && (address == A_SCRATCH);
    assign tx_push_req = wr_commit && (address == A_TXDATA);
    assign rx_pop_req  = rd_end && (address == A_RXDATA);

    assign clr  = {wr_ctrl && wr_data[1], wr_ctrl && wr_data[0]};
    assign push = {rx_valid && !full[1], tx_push_req && !full[0]};
    assign pop  = {rx_pop_req && !empty[1], tx_ready && !empty[0]};
    assign din  = {rx_data, wr_data};

    assign tx_ovf_set = tx_push_req && full[0] && !clr[0];
    assign rx_unf_set = rx_pop_req && empty[1] && !clr[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
            logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
            logic [LW-1:0]         level_reg;

            always_ff @(posedge clk) begin
                if (push[gi] && !clr[gi])
                    mem_reg[wr_ptr_reg] <= din[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else if (clr[gi]) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else begin
                    if (push[gi])
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    if (pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    case ({push[gi], pop[gi]})
                        2'b10:   level_reg <= level_reg + LW'(1);
                        2'b01:   level_reg <= level_reg - LW'(1);
                        default: level_reg <= level_reg;
                    endcase
                end
            end

            assign head[gi]  = mem_reg[rd_ptr_reg];
            assign level[gi] = level_reg;
            assign full[gi]  = (level_reg == LW'(FIFO_DEPTH));
            assign empty[gi] = (level_reg == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_d_reg   <= 1'b1;
            oe_d_reg   <= 1'b1;
            we_arm_reg <= 1'b0;
        end else begin
            we_d_reg   <= we;
            oe_d_reg   <= oe;
            we_arm_reg <= we_arm_reg || we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_hi_reg   <= '0;
            irq_en_rx_reg <= 1'b0;
            irq_en_tx_reg <= 1'b0;
            scratch_reg   <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_hi_reg   <= wr_data[15:8];
                irq_en_rx_reg <= wr_data[2];
                irq_en_tx_reg <= wr_data[3];
            end
            if (wr_scratch)
                scratch_reg <= wr_data;
        end
    end

    // Sticky error flags: a same-cycle set beats the write-one-to-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf_reg <= 1'b0;
            rx_unf_reg <= 1'b0;
        end else begin
            if (tx_ovf_set)
                tx_ovf_reg <= 1'b1;
            else if (wr_status && wr_data[4])
                tx_ovf_reg <= 1'b0;
            if (rx_unf_set)
                rx_unf_reg <= 1'b1;
            else if (wr_status && wr_data[5])
                rx_unf_reg <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            A_ID:      rd_mux = ID_VALUE;
            A_CTRL:    rd_mux = DATA_WIDTH'({ctrl_hi_reg, 4'b0000, irq_en_tx_reg, irq_en_rx_reg, 2'b00});
            A_STATUS:  rd_mux = DATA_WIDTH'({rx_unf_reg, tx_ovf_reg, empty[1], full[1], empty[0], full[0]});
            A_TXLEVEL: rd_mux = DATA_WIDTH'(level[0]);
            A_RXLEVEL: rd_mux = DATA_WIDTH'(level[1]);
            A_RXDATA:  rd_mux = empty[1] ? '0 : head[1];
            A_SCRATCH: rd_mux = scratch_reg;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            rd_data_reg <= rd_mux;
            irq_reg     <= (irq_en_rx_reg && !empty[1]) || (irq_en_tx_reg && empty[0]);
        end
    end

    assign rd_data  = rd_data_reg;
    assign irq      = irq_reg;
    assign ctrl_out = ctrl_hi_reg;
    assign tx_data  = head[0];
    assign tx_valid = !empty[0];
    assign rx_ready = !full[1];
endmodule

// File: tb/tb_gpmc_fifo_regs.sv
// Testbench for gpmc_fifo_regs: host bus transactions and fabric handshakes
// checked against a queue-based model of the register map.
module tb_gpmc_fifo_regs;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1, we = 1'b1, oe = 1'b1;
    logic [4:0]  address = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic [7:0]  ctrl_out;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model
    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    logic        m_tx_ovf, m_rx_unf, m_en_rx, m_en_tx;
    logic [7:0]  m_ctrl_hi;
    logic [15:0] m_scratch;

    gpmc_fifo_regs dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .oe(oe),
        .address(address), .wr_data(wr_data), .rd_data(rd_data),
        .ctrl_out(ctrl_out), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        txq.delete(); rxq.delete();
        m_tx_ovf = 0; m_rx_unf = 0; m_en_rx = 0; m_en_tx = 0;
        m_ctrl_hi = '0; m_scratch = '0;
    endtask

    function automatic logic [15:0] m_status();
        return {10'b0, m_rx_unf, m_tx_ovf, rxq.size() == 0, rxq.size() == DEPTH,
                txq.size() == 0, txq.size() == DEPTH};
    endfunction

    function automatic logic m_irq();
        return (m_en_rx && rxq.size() != 0) || (m_en_tx && txq.size() == 0);
    endfunction

    function automatic logic [15:0] exp_read(input logic [4:0] a);
        case (a)
            5'h00: return 16'hB3A7;
            5'h01: return {m_ctrl_hi, 4'b0, m_en_tx, m_en_rx, 2'b0};
            5'h02: return m_status();
            5'h03: return 16'(txq.size());
            5'h04: return 16'(rxq.size());
            5'h06: return (rxq.size() != 0) ? rxq[0] : 16'h0000;
            5'h08: return m_scratch;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [15:0] d);
        case (a)
            5'h01: begin
                if (d[0]) txq.delete();
                if (d[1]) rxq.delete();
                m_en_rx = d[2]; m_en_tx = d[3]; m_ctrl_hi = d[15:8];
            end
            5'h02: begin
                if (d[4]) m_tx_ovf = 0;
                if (d[5]) m_rx_unf = 0;
            end
            5'h05: if (txq.size() < DEPTH) txq.push_back(d); else m_tx_ovf = 1;
            5'h08: m_scratch = d;
            default: ;
        endcase
    endtask

    task automatic host_write(input logic [4:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        address = a; wr_data = d; cs = 0; we = 0;
        repeat (hold) @(negedge clk);
        we = 1; cs = 1;
        @(negedge clk);
        model_write(a, d);
    endtask

    task automatic host_read(input logic [4:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a; cs = 0; oe = 0;
        repeat (2) @(negedge clk);
        d = rd_data;
        oe = 1; cs = 1;
        repeat (2) @(negedge clk);
        if (a == 5'h06) begin
            if (rxq.size() != 0) void'(rxq.pop_front());
            else m_rx_unf = 1;
        end
    endtask

    task automatic rx_push(input logic [15:0] d);
        n_checks++;
        if (rx_ready !== (rxq.size() != DEPTH)) begin
            n_fail++;
            $display("FAIL rx_ready before push: got %b expected %b", rx_ready, rxq.size() != DEPTH);
        end
        rx_data = d; rx_valid = 1;
        @(negedge clk);
        rx_valid = 0;
        if (rxq.size() < DEPTH) rxq.push_back(d);
    endtask

    task automatic test_reset();
        logic [15:0] got, exp;
        logic [4:0] addrs [8] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h06, 5'h08, 5'h07};
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_data, ctrl_out, tx_valid, rx_ready, irq} !== {16'h0, 8'h0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset outputs: got rd=%h ctrl=%h txv=%b rxr=%b irq=%b expected 0 0 0 1 0",
                     rd_data, ctrl_out, tx_valid, rx_ready, irq);
        end
        rst_n = 1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp = exp_read(addrs[i]);
            host_read(addrs[i], got);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset read addr %h: got %h expected %h", addrs[i], got, exp);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_regs();
        logic [15:0] got, exp, d;
        host_write(5'h08, 16'h5A5A, 5);
        host_write(5'h01, 16'hC300, 5);
        host_read(5'h08, got);
        n_checks++;
        if (got !== 16'h5A5A) begin n_fail++; $display("FAIL scratch readback: got %h expected 5a5a", got); end
        host_read(5'h01, got);
        n_checks++;
        if (got !== 16'hC300) begin n_fail++; $display("FAIL ctrl readback: got %h expected c300", got); end
        n_checks++;
        if (ctrl_out !== 8'hC3) begin n_fail++; $display("FAIL ctrl_out: got %h expected c3", ctrl_out); end
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            host_write(5'h08, d, $urandom_range(1, 6));
            d = 16'($urandom) & 16'hFFFC;
            host_write(5'h01, d, $urandom_range(1, 6));
            host_write(5'h07, 16'($urandom), 2);
            host_write(5'h1F, 16'($urandom), 2);
            for (int a = 1; a <= 8; a++) begin
                if (a == 5 || a == 6) continue;
                exp = exp_read(5'(a));
                host_read(5'(a), got);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random reg read addr %0d: got %h expected %h", a, got, exp);
                end
            end
            n_checks++;
            if (ctrl_out !== m_ctrl_hi || irq !== m_irq()) begin
                n_fail++;
                $display("FAIL ctrl_out/irq: got %h/%b expected %h/%b", ctrl_out, irq, m_ctrl_hi, m_irq());
            end
        end
        host_write(5'h01, 16'h0000, 1);
        $display("test_regs done");
    endtask

    task automatic drain_tx(input bit random_ready, input string tag);
        logic r;
        for (int c = 0; c < 120; c++) begin
            n_checks++;
            if (tx_valid !== (txq.size() != 0) || (txq.size() != 0 && tx_data !== txq[0])) begin
                n_fail++;
                $display("FAIL %s tx head: got v=%b d=%h expected v=%b d=%h", tag, tx_valid, tx_data,
                         txq.size() != 0, (txq.size() != 0) ? txq[0] : 16'h0);
            end
            if (txq.size() == 0 && c > 2) break;
            r = random_ready ? 1'($urandom) : 1'b1;
            tx_ready = r;
            if (r && txq.size() != 0) void'(txq.pop_front());
            @(negedge clk);
        end
        tx_ready = 0;
    endtask

    task automatic test_tx_overflow();
        logic [15:0] got, exp;
        tx_ready = 0;
        for (int i = 0; i < 17; i++)
            host_write(5'h05, 16'h0100 + 16'(i), $urandom_range(1, 6));
        host_read(5'h03, got);
        n_checks++;
        if (got !== 16'd16) begin n_fail++; $display("FAIL tx level full: got %h expected 0010", got); end
        exp = exp_read(5'h02);
        host_read(5'h02, got);
        n_checks++;
        if (got !== exp || got[4] !== 1'b1 || got[0] !== 1'b1) begin
            n_fail++; $display("FAIL tx overflow status: got %h expected %h", got, exp);
        end
        drain_tx(1'b0, "tx drain");
        host_write(5'h02, 16'h0010, 1);
        exp = exp_read(5'h02);
        host_read(5'h02, got);
        n_checks++;
        if (got !== exp || got[4] !== 1'b0) begin
            n_fail++; $display("FAIL tx overflow w1c: got %h expected %h", got, exp);
        end
        for (int i = $urandom_range(3, 10); i > 0; i--)
            host_write(5'h05, 16'($urandom), $urandom_range(1, 4));
        drain_tx(1'b1, "tx random drain");
        $display("test_tx_overflow done");
    endtask

    task automatic test_rx_irq();
        logic [15:0] got, exp;
        rx_push(16'hAAAA);
        rx_push(16'hBBBB);
        host_write(5'h01, 16'h0004, 1);
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL rx irq assert: got %b expected 1", irq); end
        for (int i = 0; i < 3; i++) begin
            exp = exp_read(5'h06);
            host_read(5'h06, got);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rx read %0d: got %h expected %h", i, got, exp); end
            if (i == 1) begin
                n_checks++;
                if (irq !== 1'b0) begin n_fail++; $display("FAIL rx irq drop: got %b expected 0", irq); end
            end
        end
        exp = exp_read(5'h02);
        host_read(5'h02, got);
        n_checks++;
        if (got !== exp || got[5] !== 1'b1) begin
            n_fail++; $display("FAIL rx underflow status: got %h expected %h", got, exp);
        end
        host_write(5'h02, 16'h0020, 1);
        host_write(5'h01, 16'h0000, 1);
        for (int i = 0; i < 18; i++) rx_push(16'($urandom));
        for (int a = 2; a <= 4; a++) begin
            exp = exp_read(5'(a));
            host_read(5'(a), got);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rx full read addr %0d: got %h expected %h", a, got, exp); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = exp_read(5'h06);
            host_read(5'h06, got);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL rx drain %0d: got %h expected %h", i, got, exp); end
        end
        $display("test_rx_irq done");
    endtask

    task automatic test_simultaneous();
        logic [15:0] got, exp;
        tx_ready = 0;
        for (int i = 0; i < DEPTH; i++) host_write(5'h05, 16'($urandom), 1);
        for (int i = 0; i < DEPTH; i++) rx_push(16'($urandom));
        rx_valid = 1; rx_data = 16'hDEAD;
        // Push to full TX in the same cycle as a pop: the push is dropped.
        @(negedge clk);
        address = 5'h05; wr_data = 16'h7777; cs = 0; we = 0; tx_ready = 1;
        @(negedge clk);
        tx_ready = 0; we = 1; cs = 1;
        void'(txq.pop_front()); m_tx_ovf = 1;
        @(negedge clk);
        n_checks++;
        if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready held full: got %b expected 0", rx_ready); end
        rx_valid = 0;
        for (int a = 2; a <= 4; a++) begin
            exp = exp_read(5'(a));
            host_read(5'(a), got);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL full push+pop addr %0d: got %h expected %h", a, got, exp); end
        end
        // Push and pop together below full: level unchanged.
        @(negedge clk);
        address = 5'h05; wr_data = 16'h8888; cs = 0; we = 0; tx_ready = 1;
        @(negedge clk);
        tx_ready = 0; we = 1; cs = 1;
        void'(txq.pop_front()); txq.push_back(16'h8888);
        @(negedge clk);
        host_read(5'h03, got);
        n_checks++;
        if (got !== 16'd15) begin n_fail++; $display("FAIL push+pop level: got %h expected 000f", got); end
        drain_tx(1'b0, "simultaneous drain");
        host_write(5'h02, 16'h0030, 1);
        // TX clear while the fabric pops: FIFO ends empty.
        for (int i = 0; i < 3; i++) host_write(5'h05, 16'($urandom), 1);
        @(negedge clk);
        address = 5'h01; wr_data = 16'h0001; cs = 0; we = 0; tx_ready = 1;
        @(negedge clk);
        tx_ready = 0; we = 1; cs = 1;
        model_write(5'h01, 16'h0001);
        // RX (full) clear while the fabric pushes: the push is discarded.
        @(negedge clk);
        address = 5'h01; wr_data = 16'h0002; cs = 0; we = 0; rx_valid = 1; rx_data = 16'h4242;
        @(negedge clk);
        rx_valid = 0; we = 1; cs = 1;
        model_write(5'h01, 16'h0002);
        @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL clear flags: got txv=%b rxr=%b expected 0 1", tx_valid, rx_ready);
        end
        for (int a = 2; a <= 4; a++) begin
            exp = exp_read(5'(a));
            host_read(5'(a), got);
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL clear read addr %0d: got %h expected %h", a, got, exp); end
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        tx_ready = 0;
        host_write(5'h08, 16'h1357, 1);
        for (int i = 0; i < 3; i++) host_write(5'h05, 16'h0300 + 16'(i), 1);
        host_read(5'h03, got);
        n_checks++;
        if (got !== 16'd3) begin n_fail++; $display("FAIL pre-reset level: got %h expected 0003", got); end
        @(negedge clk);
        address = 5'h05; wr_data = 16'h1234; cs = 0; we = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || rd_data !== 16'h0) begin
            n_fail++; $display("FAIL async reset: got txv=%b rxr=%b rd=%h expected 0 1 0", tx_valid, rx_ready, rd_data);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        model_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL held strobe after reset: got txv=%b expected 0", tx_valid); end
        we = 1; cs = 1;
        @(negedge clk);
        host_read(5'h03, got);
        n_checks++;
        if (got !== 16'd0) begin n_fail++; $display("FAIL post-reset level: got %h expected 0000", got); end
        host_read(5'h08, got);
        n_checks++;
        if (got !== 16'd0) begin n_fail++; $display("FAIL post-reset scratch: got %h expected 0000", got); end
        host_write(5'h05, 16'hBEEF, 2);
        host_read(5'h03, got);
        n_checks++;
        if (got !== 16'd1 || tx_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL post-reset push: got level %h data %h expected 0001 beef", got, tx_data);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_regs();
        test_tx_overflow();
        test_rx_irq();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
